// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the 36-to-32 bit host gearbox.
package gearbox_pkg;

    localparam int FIFO_WIDTH = 36;
    localparam int OUT_WIDTH  = 32;
    localparam int BUF_WIDTH  = 68;
    localparam int GEAR_NUM   = 9;
    localparam int GEAR_DEN   = 8;

    // Eight 36-bit words carry exactly nine 32-bit words, so a frame never needs padding.
    function automatic int out_words_per_frame(input int frame_words);
        return (frame_words * GEAR_NUM) / GEAR_DEN;
    endfunction

endpackage

// File: rtl/fifo_host_gearbox.sv
// Repacks 36-bit capture FIFO words LSB-first into a 32-bit valid/ready host stream,
// flagging the last word of each frame and counting completed frames.
module fifo_host_gearbox
    import gearbox_pkg::*;
#(
    parameter int FRAME_WORDS = 64,
    parameter int FCNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic [OUT_WIDTH-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic [FCNT_WIDTH-1:0] frame_count
);

    localparam int OUT_FRAME = out_words_per_frame(FRAME_WORDS);
    localparam int OCNT_W    = $clog2(OUT_FRAME);
    localparam int ICNT_W    = $clog2(FRAME_WORDS + 1);
    localparam int CNT_W     = $clog2(BUF_WIDTH);
    localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_FRAME - 1);
    localparam logic [CNT_W-1:0]  OUT_BITS = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0]  IN_BITS  = CNT_W'(FIFO_WIDTH);

    if (FRAME_WORDS <= 0 || (FRAME_WORDS % GEAR_DEN) != 0) begin : g_bad_frame_words
        $error("fifo_host_gearbox: FRAME_WORDS must be a nonzero multiple of 8");
    end

    logic [BUF_WIDTH-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ICNT_W-1:0]     in_cnt_q, in_cnt_d;
    logic [OCNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [FCNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic                  handshake;
    logic                  last_handshake;
    logic [BUF_WIDTH-1:0]  buf_shift;
    logic [CNT_W-1:0]      cnt_shift;

    // Reads only start while less than one output word is buffered, which keeps cnt <= 67.
    assign fifo_rd_en  = !fifo_empty && !rd_pend_q && (cnt_q < OUT_BITS) && !rst;
    assign dout        = buf_q[OUT_WIDTH-1:0];
    assign dout_valid  = (cnt_q >= OUT_BITS);
    assign dout_last   = dout_valid && (out_cnt_q == OUT_LAST);
    assign frame_count = frame_count_q;

    assign handshake      = dout_valid && dout_ready;
    assign last_handshake = handshake && (out_cnt_q == OUT_LAST);

    // Output shift is applied before the returning read word is appended behind it.
    always_comb begin
        buf_shift     = buf_q;
        cnt_shift     = cnt_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        rd_pend_d     = fifo_rd_en;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        frame_count_d = frame_count_q;

        if (handshake) begin
            buf_shift = buf_q >> OUT_WIDTH;
            cnt_shift = cnt_q - OUT_BITS;
        end
        buf_d = buf_shift;
        cnt_d = cnt_shift;

        if (rd_pend_q) begin
            buf_d    = buf_shift | (BUF_WIDTH'(fifo_dout) << cnt_shift);
            cnt_d    = cnt_shift + IN_BITS;
            in_cnt_d = in_cnt_q + ICNT_W'(1);
        end

        if (handshake) begin
            out_cnt_d = out_cnt_q + OCNT_W'(1);
        end

        if (last_handshake) begin
            out_cnt_d     = '0;
            in_cnt_d      = rd_pend_q ? ICNT_W'(1) : '0;
            frame_count_d = frame_count_q + FCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q         <= '0;
            cnt_q         <= '0;
            rd_pend_q     <= 1'b0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            frame_count_q <= '0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            rd_pend_q     <= rd_pend_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
